// File: rtl/serial_pkg.sv
// -----------------------------------------------------------------------------
// serial_pkg
// Constants shared by the serial link transmitter and receiver.
//   - FSM state encodings (IDLE/START/DATA/STOP)
//   - Line-level values for the idle line, the start bit and the stop bit
// -----------------------------------------------------------------------------
package serial_pkg;

    typedef logic [1:0] serial_state_t;

    localparam serial_state_t IDLE  = 2'd0;
    localparam serial_state_t START = 2'd1;
    localparam serial_state_t DATA  = 2'd2;
    localparam serial_state_t STOP  = 2'd3;

    localparam logic LINE_IDLE = 1'b1;
    localparam logic START_BIT = 1'b0;
    localparam logic STOP_BIT  = 1'b1;

endpackage

// File: rtl/serial_bit_timer.sv
// -----------------------------------------------------------------------------
// serial_bit_timer
// Free-running cycle counter that marks the last clock of every serial bit.
// Ports:
//   clk     - system clock
//   rst     - synchronous active-high reset
//   clear   - restart the bit period (counter to 0 on this edge)
//   bitDone - high during the last cycle of the current bit period
// -----------------------------------------------------------------------------
module serial_bit_timer #(
    parameter int CLKS_PER_BIT = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    output logic bitDone
);

    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    assign bitDone = (cnt_q == LAST);

    always_comb begin
        cnt_d = cnt_q + 1'b1;
        if (clear || bitDone) cnt_d = '0;
    end

    always_ff @(posedge clk) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end

endmodule

// File: rtl/serial_tx_nbits.sv
// -----------------------------------------------------------------------------
// serial_tx_nbits
// Serial link transmitter: takes an NBITS word over a valid/ready handshake and
// sends it LSB-first framed by a start bit (0) and a stop bit (1), each bit
// held for CLKS_PER_BIT clocks.
// Ports:
//   clk       - system clock
//   rst       - synchronous active-high reset
//   data      - parallel word to send
//   dataValid - data holds a word to send
//   dataReady - a word is accepted on this edge if dataValid is also high
//   txSerial  - serial line, idles high, driven from a flop
//   busy      - frame in progress
// -----------------------------------------------------------------------------
module serial_tx_nbits
    import serial_pkg::*;
#(
    parameter int NBITS        = 8,
    parameter int CLKS_PER_BIT = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [NBITS-1:0] data,
    input  logic             dataValid,
    output logic             dataReady,
    output logic             txSerial,
    output logic             busy
);

    localparam int BW = (NBITS > 1) ? $clog2(NBITS) : 1;
    localparam logic [BW-1:0] LAST_BIT = BW'(NBITS - 1);

    serial_state_t    state_q, state_d;
    logic [BW-1:0]    bitCnt_q, bitCnt_d;
    logic [NBITS-1:0] shift_q, shift_d, shifted;
    logic             tx_q, tx_d;
    logic             busy_q, busy_d;
    logic             ready_q, ready_d;
    logic             accept;
    logic             bitDone;

    assign accept  = ready_q && dataValid;
    assign shifted = shift_q >> 1;

    // Bit period restarts on acceptance so the start bit gets a full period.
    serial_bit_timer #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_timer (
        .clk    (clk),
        .rst    (rst),
        .clear  (accept),
        .bitDone(bitDone)
    );

    always_comb begin
        state_d  = state_q;
        bitCnt_d = bitCnt_q;
        shift_d  = shift_q;
        tx_d     = tx_q;
        case (state_q)
            IDLE: begin
                if (dataValid) begin
                    shift_d  = data;
                    bitCnt_d = '0;
                    tx_d     = START_BIT;
                    state_d  = START;
                end
            end
            START: begin
                if (bitDone) begin
                    tx_d    = shift_q[0];
                    state_d = DATA;
                end
            end
            DATA: begin
                if (bitDone) begin
                    shift_d = shifted;
                    if (bitCnt_q == LAST_BIT) begin
                        tx_d    = STOP_BIT;
                        state_d = STOP;
                    end else begin
                        // Counter stops at NBITS-1 so it never wraps.
                        bitCnt_d = bitCnt_q + 1'b1;
                        tx_d     = shifted[0];
                    end
                end
            end
            STOP: begin
                if (bitDone) begin
                    tx_d    = LINE_IDLE;
                    state_d = IDLE;
                end
            end
            default: begin
                tx_d    = LINE_IDLE;
                state_d = IDLE;
            end
        endcase
        busy_d  = (state_d != IDLE);
        ready_d = (state_d == IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            bitCnt_q <= '0;
            shift_q  <= '0;
            tx_q     <= LINE_IDLE;
            busy_q   <= 1'b0;
            ready_q  <= 1'b1;
        end else begin
            state_q  <= state_d;
            bitCnt_q <= bitCnt_d;
            shift_q  <= shift_d;
            tx_q     <= tx_d;
            busy_q   <= busy_d;
            ready_q  <= ready_d;
        end
    end

    assign dataReady = ready_q;
    assign txSerial  = tx_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_serial_tx_nbits.sv
// -----------------------------------------------------------------------------
// tb_serial_tx_nbits
// Two transmitters: u0 with CLKS_PER_BIT=4, u1 with CLKS_PER_BIT=1, both 8-bit.
// Stimulus pushes expected frames into per-instance queues; a monitor per
// instance watches the line, captures each frame and compares.
// -----------------------------------------------------------------------------
module tb_serial_tx_nbits;

    typedef struct {
        logic [7:0] w;
        int         gap;    // expected idle cycles before start, -1 = don't care
        bit         abort;  // frame is expected to be cut by reset
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] data0 = '0, data1 = '0;
    logic       dv0 = 1'b0, dv1 = 1'b0;
    logic       rdy0, rdy1, tx0, tx1, busy0, busy1;

    int checks = 0;
    int errors = 0;
    exp_t q0[$];
    exp_t q1[$];

    always #5 clk = ~clk;

    serial_tx_nbits #(.NBITS(8), .CLKS_PER_BIT(4)) u0 (
        .clk(clk), .rst(rst), .data(data0), .dataValid(dv0),
        .dataReady(rdy0), .txSerial(tx0), .busy(busy0)
    );

    serial_tx_nbits #(.NBITS(8), .CLKS_PER_BIT(1)) u1 (
        .clk(clk), .rst(rst), .data(data1), .dataValid(dv1),
        .dataReady(rdy1), .txSerial(tx1), .busy(busy1)
    );

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%h exp=%h t=%0t", nm, act, exp, $time);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // {tx, busy, ready}
    function automatic logic [2:0] lines(input int idx);
        return (idx == 0) ? {tx0, busy0, rdy0} : {tx1, busy1, rdy1};
    endfunction

    task automatic monitor(input int idx);
        int          cpb;
        int          gap;
        int          startGap;
        logic [63:0] obs, expv;
        logic [9:0]  fr;
        logic [2:0]  l;
        bit          bad, aborted;
        exp_t        e;
        cpb = (idx == 0) ? 4 : 1;
        gap = -1;
        forever begin
            // Idle: wait for the start bit, the DUT must sit in IDLE meanwhile.
            forever begin
                @(negedge clk);
                l = lines(idx);
                if (l[2] == 1'b0) break;
                chk($sformatf("idle_hs%0d", idx), {62'd0, l[1:0]}, 64'b01);
                if (gap >= 0) gap++;
            end
            startGap = gap;
            obs = '0; bad = 0; aborted = 0;
            for (int i = 0; i < 10 * cpb; i++) begin
                if (i > 0) @(negedge clk);
                if (rst) begin aborted = 1; break; end
                l = lines(idx);
                obs[i] = l[2];
                if (l[1:0] !== 2'b10) bad = 1;
            end
            if ((idx == 0 ? q0.size() : q1.size()) == 0) begin
                chk($sformatf("unexpected_frame%0d", idx), obs, 64'd0);
                gap = -1;
                continue;
            end
            e = (idx == 0) ? q0.pop_front() : q1.pop_front();
            chk($sformatf("abort%0d", idx), {63'd0, aborted}, {63'd0, e.abort});
            if (aborted) begin
                @(negedge clk);
                chk($sformatf("reset_line%0d", idx), {61'd0, lines(idx)}, 64'b101);
                gap = -1;
                continue;
            end
            fr = {1'b1, e.w, 1'b0};
            expv = '0;
            for (int i = 0; i < 10 * cpb; i++) expv[i] = fr[i / cpb];
            chk($sformatf("frame%0d_%h", idx, e.w), obs, expv);
            chk($sformatf("busy_rdy%0d_%h", idx, e.w), {63'd0, bad}, 64'd0);
            if (e.gap >= 0)
                chk($sformatf("gap%0d_%h", idx, e.w), 64'(startGap), 64'(e.gap));
            // Edge k+frame length: back in IDLE.
            @(negedge clk);
            chk($sformatf("end_line%0d_%h", idx, e.w), {61'd0, lines(idx)}, 64'b101);
            gap = 1;
        end
    endtask

    // Called just after a posedge; returns just after the accepting edge.
    task automatic send(input int idx, input logic [7:0] w, input int gap,
                        input bit abort, input bit hold);
        exp_t e;
        bit   r;
        int   n;
        e.w = w; e.gap = gap; e.abort = abort;
        if (idx == 0) begin q0.push_back(e); data0 = w; dv0 = 1'b1; end
        else          begin q1.push_back(e); data1 = w; dv1 = 1'b1; end
        n = 0;
        do begin
            @(negedge clk);
            r = (idx == 0) ? rdy0 : rdy1;
            @(posedge clk);
            n++;
        end while (!r && n < 200);
        if (!r) chk($sformatf("accept_timeout%0d", idx), 64'd0, 64'd1);
        #1;
        if (!hold) begin
            if (idx == 0) dv0 = 1'b0; else dv1 = 1'b0;
        end
    endtask

    task automatic drain(input int idx);
        int n = 0;
        while ((idx == 0 ? q0.size() : q1.size()) > 0 && n < 1000) begin
            @(posedge clk);
            n++;
        end
        chk($sformatf("drain%0d", idx), 64'(idx == 0 ? q0.size() : q1.size()), 64'd0);
        cyc(3);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog act=running exp=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        cyc(2);
        rst = 1'b0;
        fork
            monitor(0);
            monitor(1);
        join_none
        // Idle line after reset.
        cyc(20);

        // Single frame.
        send(0, 8'hA5, -1, 0, 0);
        drain(0);

        // Data changes mid-frame with dataValid high: only 3C goes out first,
        // then FF is accepted on the first IDLE cycle.
        send(0, 8'h3C, -1, 0, 0);
        cyc(9);
        send(0, 8'hFF, 1, 0, 0);
        drain(0);

        // Back-to-back with dataValid held.
        send(0, 8'h00, -1, 0, 1);
        send(0, 8'hFF, 1, 0, 0);
        drain(0);

        // Reset mid-frame, then a clean frame.
        send(0, 8'h0F, -1, 1, 0);
        cyc(14);
        rst = 1'b1;
        cyc(1);
        rst = 1'b0;
        cyc(3);
        send(0, 8'h81, -1, 0, 0);
        drain(0);

        // Reset together with dataValid: nothing captured, line stays idle.
        dv0 = 1'b1; data0 = 8'h55; rst = 1'b1;
        cyc(1);
        rst = 1'b0; dv0 = 1'b0;
        cyc(5);

        // One clock per bit.
        send(1, 8'h81, -1, 0, 1);
        send(1, 8'h7E, 1, 0, 0);
        drain(1);

        cyc(5);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
